// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Posted-write FIFO between store alignment and the memory bus,
//               with misaligned-store trap and load-after-store hazard check.
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_valid,
    output logic          push_ready,
    input  logic [31:0]   push_addr,
    input  logic [31:0]   push_data,
    input  logic [3:0]    push_wmask,
    input  logic          push_unaligned,
    output logic          trap_valid,
    output logic [31:0]   trap_addr,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic [31:0]   load_addr,
    input  logic          load_valid,
    output logic          load_hazard,
    output logic [AW:0]   count,
    output logic          empty
);

    localparam logic [AW:0] c_FULL_COUNT = (AW + 1)'(DEPTH);

    logic [29:0]   r_word  [DEPTH];
    logic [31:0]   r_data  [DEPTH];
    logic [3:0]    r_wmask [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic          r_trap_valid;
    logic [31:0]   r_trap_addr;

    logic          w_full;
    logic          w_accept;
    logic          w_write;
    logic          w_pop;
    logic          w_hazard;

    assign w_full   = (r_count == c_FULL_COUNT);
    assign w_accept = push_valid && !w_full;
    // Zero-mask stores are accepted but carry no bytes, so they never occupy a slot.
    assign w_write  = w_accept && !push_unaligned && (push_wmask != 4'b0000);
    assign w_pop    = (r_count != '0) && mem_ready;

    assign push_ready  = !w_full;
    assign empty       = (r_count == '0);
    assign count       = r_count;
    assign mem_valid   = !empty;
    assign mem_addr    = {r_word[r_rd_ptr], 2'b00};
    assign mem_wdata   = r_data[r_rd_ptr];
    assign mem_wstrb   = r_wmask[r_rd_ptr];
    assign trap_valid  = r_trap_valid;
    assign trap_addr   = r_trap_addr;
    assign load_hazard = w_hazard;

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_word[r_wr_ptr]  <= push_addr[31:2];
            r_data[r_wr_ptr]  <= push_data;
            r_wmask[r_wr_ptr] <= push_wmask;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_trap_valid <= 1'b0;
            r_trap_addr  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_write && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_write && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            r_trap_valid <= w_accept && push_unaligned;
            if (w_accept && push_unaligned) begin
                r_trap_addr <= push_addr;
            end
        end
    end

    // Scan slots by distance from the head so only occupied entries are compared.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (((AW + 1)'(i) < r_count) &&
                (r_word[r_rd_ptr + AW'(i)] == load_addr[31:2])) begin
                w_hazard = 1'b1;
            end
        end
        w_hazard = w_hazard && load_valid;
    end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Self-checking bench for store_buffer against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          reset;
    logic          push_valid;
    logic          push_ready;
    logic [31:0]   push_addr;
    logic [31:0]   push_data;
    logic [3:0]    push_wmask;
    logic          push_unaligned;
    logic          trap_valid;
    logic [31:0]   trap_addr;
    logic          mem_valid;
    logic          mem_ready;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic [31:0]   load_addr;
    logic          load_valid;
    logic          load_hazard;
    logic [AW:0]   count;
    logic          empty;

    store_buffer #(.DEPTH(DEPTH)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .push_valid     (push_valid),
        .push_ready     (push_ready),
        .push_addr      (push_addr),
        .push_data      (push_data),
        .push_wmask     (push_wmask),
        .push_unaligned (push_unaligned),
        .trap_valid     (trap_valid),
        .trap_addr      (trap_addr),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .load_addr      (load_addr),
        .load_valid     (load_valid),
        .load_hazard    (load_hazard),
        .count          (count),
        .empty          (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } store_t;

    store_t      r_model_q[$];
    logic        r_exp_trap_valid;
    logic [31:0] r_exp_trap_addr;
    int          r_tests;
    int          r_fails;
    bit          r_checking;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_tests++;
        if (obs !== exp) begin
            r_fails++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic hz;
        int   n;
        n = r_model_q.size();
        check_val("push_ready", 32'(push_ready), 32'(n < DEPTH));
        check_val("count", 32'(count), 32'(n));
        check_val("empty", 32'(empty), 32'(n == 0));
        check_val("mem_valid", 32'(mem_valid), 32'(n != 0));
        if (n != 0) begin
            check_val("mem_addr", mem_addr, r_model_q[0].addr & 32'hFFFF_FFFC);
            check_val("mem_wdata", mem_wdata, r_model_q[0].data);
            check_val("mem_wstrb", 32'(mem_wstrb), 32'(r_model_q[0].mask));
        end
        check_val("trap_valid", 32'(trap_valid), 32'(r_exp_trap_valid));
        check_val("trap_addr", trap_addr, r_exp_trap_addr);
        hz = 1'b0;
        foreach (r_model_q[i]) begin
            if ((r_model_q[i].addr >> 2) == (load_addr >> 2)) hz = 1'b1;
        end
        check_val("load_hazard", 32'(load_hazard), 32'(hz && load_valid));
    endtask

    task automatic model_update();
        bit acc;
        if (reset) begin
            r_model_q.delete();
            r_exp_trap_valid = 1'b0;
            r_exp_trap_addr  = 32'h0;
            return;
        end
        acc = push_valid && (r_model_q.size() < DEPTH);
        if ((r_model_q.size() != 0) && mem_ready) void'(r_model_q.pop_front());
        r_exp_trap_valid = acc && push_unaligned;
        if (acc && push_unaligned) r_exp_trap_addr = push_addr;
        if (acc && !push_unaligned && (push_wmask != 4'b0000))
            r_model_q.push_back('{addr: push_addr, data: push_data, mask: push_wmask});
    endtask

    // One clock: inputs already driven; check at negedge, then advance the model.
    task automatic cycle();
        @(negedge clk);
        if (r_checking) check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] m, input logic u);
        push_valid     = 1'b1;
        push_addr      = a;
        push_data      = d;
        push_wmask     = m;
        push_unaligned = u;
    endtask

    initial begin
        r_tests          = 0;
        r_fails          = 0;
        r_checking       = 1'b0;
        r_exp_trap_valid = 1'b0;
        r_exp_trap_addr  = 32'h0;
        reset            = 1'b1;
        push_valid       = 1'b0;
        push_addr        = 32'h0;
        push_data        = 32'h0;
        push_wmask       = 4'h0;
        push_unaligned   = 1'b0;
        mem_ready        = 1'b0;
        load_addr        = 32'h0;
        load_valid       = 1'b0;

        cycle();
        r_checking = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();

        // Single store through an empty buffer
        mem_ready = 1'b1;
        drive_push(32'h100, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        cycle();
        push_valid = 1'b0;
        cycle();
        cycle();

        // Fill to DEPTH, hold a fifth push, then drain in order
        mem_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_push(32'(i * 4), 32'hA000_0000 + 32'(i), 4'b1111, 1'b0);
            cycle();
        end
        drive_push(32'h40, 32'h5555_5555, 4'b0011, 1'b0);
        for (int i = 0; i < 3; i++) cycle();
        push_valid = 1'b0;
        mem_ready  = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) cycle();

        // Misaligned store traps, back-to-back traps, zero-mask drop
        drive_push(32'h203, 32'h1, 4'b0001, 1'b1);
        cycle();
        drive_push(32'h301, 32'h2, 4'b0010, 1'b1);
        cycle();
        drive_push(32'h400, 32'h3, 4'b0000, 1'b0);
        cycle();
        push_valid = 1'b0;
        cycle();
        cycle();

        // Load hazard against a single pending entry
        mem_ready = 1'b0;
        drive_push(32'h1004, 32'h00AB_0000, 4'b0100, 1'b0);
        cycle();
        push_valid = 1'b0;
        load_valid = 1'b1;
        load_addr  = 32'h1006;
        cycle();
        load_addr  = 32'h1008;
        cycle();
        load_valid = 1'b0;
        load_addr  = 32'h1004;
        cycle();
        mem_ready  = 1'b1;
        cycle();

        // Steady push+pop at count 2 wraps the pointers
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_push(32'h2000 + 32'(i * 4), 32'hB000_0000 + 32'(i), 4'b1111, 1'b0);
            cycle();
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_push(32'h3000 + 32'(i * 4), 32'hC000_0000 + 32'(i), 4'(i + 1), 1'b0);
            cycle();
        end
        push_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // Reset in the middle of a drain
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_push(32'h500 + 32'(i * 4), 32'hD000_0000 + 32'(i), 4'b1111, 1'b0);
            cycle();
        end
        push_valid = 1'b0;
        mem_ready  = 1'b1;
        reset      = 1'b1;
        cycle();
        reset      = 1'b0;
        cycle();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            logic u;
            u              = ($urandom_range(0, 9) == 0);
            push_valid     = ($urandom_range(0, 2) != 0);
            push_unaligned = u;
            push_addr      = 32'h1000 + (32'($urandom_range(0, 15)) << 2) +
                             (u ? 32'($urandom_range(1, 3)) : 32'h0);
            push_data      = $urandom;
            push_wmask     = 4'($urandom_range(0, 15));
            mem_ready      = ($urandom_range(0, 2) != 0);
            load_valid     = $urandom_range(0, 1) == 1;
            load_addr      = 32'h1000 + (32'($urandom_range(0, 15)) << 2) +
                             32'($urandom_range(0, 3));
            reset          = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset      = 1'b0;
        push_valid = 1'b0;
        mem_ready  = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) cycle();

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write queue downstream of the store alignment stage.
- Accepts byte-lane-aligned store data, byte write mask and unaligned flag from the core's memory stage, and queues legal stores in a small FIFO.
- Drains queued stores in order to the memory bus through a valid/ready handshake.
- Flags misaligned stores as a registered trap, and reports load-after-store hazards so the core stalls loads that hit a pending word.

Parameters:
- DEPTH, 4: number of FIFO entries; power of two, at least 2.
- AW, $clog2(DEPTH): pointer width; derived, do not override.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- push_valid  input  1  core presents a store
- push_ready  output  1  buffer can accept a store; equals !full
- push_addr  input  32  byte address of the store
- push_data  input  32  lane-aligned store data
- push_wmask  input  4  byte write mask
- push_unaligned  input  1  store is misaligned
- trap_valid  output  1  one-cycle misaligned-store trap pulse
- trap_addr  output  32  address of the trapping store
- mem_valid  output  1  head entry presented to the bus
- mem_ready  input  1  bus accepts the head entry
- mem_addr  output  32  {head word address, 2'b00}
- mem_wdata  output  32  head data
- mem_wstrb  output  4  head byte mask
- load_addr  input  32  address of the load in the memory stage
- load_valid  input  1  qualifies load_addr
- load_hazard  output  1  load overlaps a pending store
- count  output  AW+1  number of occupied entries
- empty  output  1  count == 0

Behaviour:
- Reset values:
  - rd_ptr, wr_ptr and count = 0.
  - trap_valid = 0, trap_addr = 0.
  - mem_valid = 0, empty = 1, push_ready = 1.
  - Reset mid-drain discards every entry; mem_valid drops to 0 the next cycle, regardless of mem_ready.
- Accept condition: push_valid && push_ready.
  - If push_unaligned = 0 and push_wmask != 0: write an entry {push_addr[31:2], push_data, push_wmask} at wr_ptr, then increment wr_ptr. Pointers wrap modulo DEPTH.
  - If push_unaligned = 1: no entry is written. Next cycle, trap_valid = 1 for exactly one cycle and trap_addr = push_addr.
  - If push_unaligned = 0 and push_wmask == 0: the store is accepted and dropped. No entry is written and no trap is raised.
- Full: push_ready = 0 while count == DEPTH. There is no same-cycle bypass of a pop into a push when full. A push_valid held while full waits with no state change.
- Drain side:
  - mem_valid = !empty; mem_addr, mem_wdata and mem_wstrb are read combinationally from the entry at rd_ptr.
  - On mem_valid && mem_ready: increment rd_ptr and decrement count.
  - While mem_valid = 1 and mem_ready = 0, the mem outputs stay stable.
- Latency: a push into an empty buffer appears on mem_valid in the following cycle. There is no combinational push-to-mem path.
- Simultaneous push and pop (not full): count is unchanged and both pointers advance.
- Ordering: strict FIFO. Entries are never merged or reordered.
- Hazard check: load_hazard = load_valid && (some occupied entry has word address == load_addr[31:2]).
  - Combinational over the occupied entries only, including the head entry during the cycle it is popped.
  - A store being pushed in the same cycle is not included; the core guarantees a one-cycle separation.
- count width AW+1 distinguishes full from empty; count never exceeds DEPTH.
- Back-to-back traps on consecutive cycles produce trap_valid high on consecutive cycles, each carrying its own trap_addr.

Test Plan:
- Reset, then push SW addr 0x100 data 0xDEADBEEF wmask 4'b1111, mem_ready=1 -> next cycle mem_valid=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, mem_wstrb=4'b1111; one cycle later empty=1.
- mem_ready=0, push DEPTH stores to 0x0, 0x4, 0x8, 0xC -> count=4, push_ready=0; a 5th push_valid is held with count unchanged. Release mem_ready -> bus sees 0x0, 0x4, 0x8, 0xC in order.
- Push with push_unaligned=1, addr 0x203 -> no entry written (count stays 0); next cycle trap_valid=1 for one cycle, trap_addr=0x203.
- Buffer holds entry 0x1004 wmask 4'b0100 -> load_addr 0x1006 with load_valid=1 gives load_hazard=1; load_addr 0x1008 gives load_hazard=0; load_valid=0 gives load_hazard=0.
- count=2, mem_ready=1, push every cycle for 8 cycles -> count stays 2 and the pointers wrap past DEPTH with no lost or duplicated stores (scoreboard check).
- Reset asserted with count=3 and mem_valid=1 -> next cycle count=0, mem_valid=0, push_ready=1, trap_valid=0.
